// File: rtl/mult_seq_arbiter.sv
// mult_seq_arbiter: round-robin arbiter and sequencer for the shared shift-add multiplier datapath
module mult_seq_arbiter #(
    parameter int N_BITS = 6,
    parameter int MUX_W  = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req_i,
    input  logic [N_BITS-1:0]   a0_i,
    input  logic [N_BITS-1:0]   b0_i,
    input  logic [N_BITS-1:0]   a1_i,
    input  logic [N_BITS-1:0]   b1_i,
    input  logic [2*N_BITS-1:0] prod_i,
    output logic [N_BITS-1:0]   op_a_o,
    output logic [N_BITS-1:0]   op_b_o,
    output logic                clr_o,
    output logic                ld_o,
    output logic [1:0]          sel_o,
    output logic [MUX_W-1:0]    mux_o,
    output logic [1:0]          gnt_o,
    output logic [1:0]          done_o,
    output logic [2*N_BITS-1:0] result_o,
    output logic                busy_o
);
    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N_BITS - 1);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_e;
    state_e              state_q;
    logic [CW-1:0]       count_q;
    logic                last_q;
    logic                win_d;
    logic                ld_q;
    logic [1:0]          sel_q;
    logic [MUX_W-1:0]    mux_q;
    logic [1:0]          gnt_q;
    logic [1:0]          done_q;
    logic [2*N_BITS-1:0] result_q;
    logic [N_BITS-1:0]   op_a_q;
    logic [N_BITS-1:0]   op_b_q;
    // round-robin winner: a lone requester wins, on contention the one not served last wins
    always_comb begin
        win_d = (req_i == 2'b11) ? ~last_q : req_i[1];
    end
    // sequencer: outputs are registered alongside the state so they track it cycle for cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            last_q   <= 1'b1;
            ld_q     <= 1'b0;
            sel_q    <= 2'b00;
            mux_q    <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            result_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_q <= LOAD;
                        last_q  <= win_d;
                        gnt_q   <= win_d ? 2'b10 : 2'b01;
                        op_a_q  <= win_d ? a1_i : a0_i;
                        op_b_q  <= win_d ? b1_i : b0_i;
                        ld_q    <= 1'b1;
                        sel_q   <= 2'b01;
                        mux_q   <= '0;
                    end
                end
                LOAD: begin
                    state_q <= SHIFT;
                    count_q <= '0;
                    sel_q   <= 2'b10;
                    mux_q   <= '0;
                end
                SHIFT: begin
                    if (count_q == LAST_STEP) begin
                        state_q <= CAPTURE;
                        ld_q    <= 1'b0;
                        sel_q   <= 2'b00;
                        mux_q   <= '0;
                    end else begin
                        count_q <= count_q + 1'b1;
                        mux_q   <= MUX_W'(count_q + 1'b1);
                    end
                end
                CAPTURE: begin
                    state_q  <= DONE;
                    result_q <= prod_i;
                    done_q   <= gnt_q;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 2'b00;
                    gnt_q   <= 2'b00;
                end
                default: begin
                    state_q <= IDLE;
                    ld_q    <= 1'b0;
                    sel_q   <= 2'b00;
                    mux_q   <= '0;
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                end
            endcase
        end
    end
    assign clr_o    = reset_n && (state_q == IDLE) && (|req_i);
    assign busy_o   = (state_q != IDLE);
    assign ld_o     = ld_q;
    assign sel_o    = sel_q;
    assign mux_o    = mux_q;
    assign gnt_o    = gnt_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign op_a_o   = op_a_q;
    assign op_b_o   = op_b_q;
endmodule

// File: tb/tb_mult_seq_arbiter.sv
// tb_mult_seq_arbiter: scoreboard bench with a behavioral shift-add datapath
module tb_mult_seq_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [5:0]  a0, b0, a1, b1;
    logic [11:0] prod;
    logic [5:0]  op_a, op_b;
    logic        clr, ld, busy;
    logic [1:0]  sel, gnt, done;
    logic [2:0]  mux;
    logic [11:0] result;
    typedef struct {
        logic [1:0]  d;
        logic [11:0] r;
        int          c;
    } exp_t;
    exp_t q[$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [11:0] acc, ar;
    logic [5:0]  br;

    mult_seq_arbiter #(.N_BITS(6), .MUX_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req),
        .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1), .prod_i(prod),
        .op_a_o(op_a), .op_b_o(op_b), .clr_o(clr), .ld_o(ld), .sel_o(sel),
        .mux_o(mux), .gnt_o(gnt), .done_o(done), .result_o(result), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioral datapath driven only by the sequencer controls
    always @(posedge clk) begin
        if (!reset_n || clr) acc <= '0;
        else if (ld && sel == 2'b01) begin
            acc <= '0;
            ar  <= {6'b0, op_a};
            br  <= op_b;
        end else if (ld && sel == 2'b10 && mux < 3'd6 && br[mux])
            acc <= acc + (ar << mux);
    end
    assign prod = acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done != 2'b00) begin
            if (q.size() == 0) chk("unexpected_done", {30'b0, done}, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("done", {30'b0, done}, {30'b0, e.d});
                chk("result", {20'b0, result}, {20'b0, e.r});
                chk("gnt_at_done", {30'b0, gnt}, {30'b0, e.d});
                chk("done_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, t;
        reset_n = 1'b0;
        req = 2'b11;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_clr", clr, 0);
        chk("rst_ld", ld, 0);
        chk("rst_sel", sel, 0);
        chk("rst_mux", mux, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        req = 2'b00;
        @(negedge clk);

        req = 2'b01; a0 = 13; b0 = 11;
        c0 = cyc;
        q.push_back('{2'b01, 12'd143, c0 + 9});
        #1;
        chk("single_clr_c0", clr, 1);
        chk("single_busy_c0", busy, 0);
        @(negedge clk);
        req = 2'b00;
        chk("single_ld_c1", ld, 1);
        chk("single_sel_c1", sel, 1);
        chk("single_gnt_c1", gnt, 1);
        chk("single_clr_c1", clr, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("single_sel_shift", sel, 2);
            chk("single_mux_shift", mux, i);
            chk("single_ld_shift", ld, 1);
        end
        @(negedge clk);
        chk("single_ld_capture", ld, 0);
        chk("single_sel_capture", sel, 0);
        run_to(c0 + 10);
        chk("single_gnt_c10", gnt, 0);
        chk("single_busy_c10", busy, 0);

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        req = 2'b11; a0 = 3; b0 = 5; a1 = 7; b1 = 9;
        c0 = cyc;
        q.push_back('{2'b01, 12'd15, c0 + 9});
        q.push_back('{2'b10, 12'd63, c0 + 19});
        run_to(c0 + 10);
        chk("cont_gnt_c10", gnt, 0);
        run_to(c0 + 11);
        chk("cont_gnt_c11", gnt, 2);
        run_to(c0 + 19);
        req = 2'b00;
        run_to(c0 + 21);

        req = 2'b11; a0 = 2; b0 = 3; a1 = 4; b1 = 5;
        c0 = cyc;
        q.push_back('{2'b01, 12'd6, c0 + 9});
        q.push_back('{2'b10, 12'd20, c0 + 19});
        q.push_back('{2'b01, 12'd6, c0 + 29});
        q.push_back('{2'b10, 12'd20, c0 + 39});
        run_to(c0 + 39);
        req = 2'b00;
        run_to(c0 + 41);

        req = 2'b01; a0 = 5; b0 = 5;
        c0 = cyc;
        run_to(c0 + 4);
        chk("abort_mux_c4", mux, 2);
        chk("abort_sel_c4", sel, 2);
        reset_n = 1'b0;
        req = 2'b00;
        @(negedge clk);
        chk("abort_ld", ld, 0);
        chk("abort_sel", sel, 0);
        chk("abort_mux", mux, 0);
        chk("abort_gnt", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_clr", clr, 0);
        reset_n = 1'b1;
        req = 2'b10; a1 = 63; b1 = 63;
        c1 = cyc;
        q.push_back('{2'b10, 12'd3969, c1 + 9});
        #1;
        chk("post_abort_clr", clr, 1);
        @(negedge clk);
        req = 2'b00;
        run_to(c1 + 11);

        req = 2'b01; a0 = 9; b0 = 7;
        c0 = cyc;
        q.push_back('{2'b01, 12'd63, c0 + 9});
        run_to(c0 + 3);
        req = 2'b00; a0 = 1; b0 = 1;
        run_to(c0 + 11);
        chk("change_busy_end", busy, 0);

        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
